// File: rtl/seq_shift_unit.sv
// Multi-cycle barrel-free shifter: one bit per clock for LSL/LSR/ASR/ROR.
// Result and carry are registered and held until the next operation ends.
module seq_shift_unit #(
  parameter int DATA_width  = 16,
  parameter int SHAMT_width = 5
) (
  input  logic                   CLK_SHIFT,
  input  logic                   RST_SHIFT,
  input  logic [DATA_width-1:0]  A_IN_SHIFT,
  input  logic [DATA_width-1:0]  B_IN_SHIFT,
  input  logic                   SEL_B,
  input  logic [SHAMT_width-1:0] SHAMT,
  input  logic [1:0]             ALU_FUN_SHIFT,
  input  logic                   Shift_EN,
  output logic                   BUSY,
  output logic                   SHIFT_FLAG,
  output logic [DATA_width-1:0]  SHIFT_OUT,
  output logic                   CARRY_OUT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  state_e                 state_q, state_d;
  logic [DATA_width-1:0]  work_q, work_d;
  logic [SHAMT_width-1:0] cnt_q, cnt_d;
  logic [1:0]             mode_q, mode_d;
  logic                   carry_q, carry_d;
  logic [DATA_width-1:0]  out_q, out_d;
  logic                   cout_q, cout_d;

  logic [DATA_width-1:0]  step_val;
  logic                   step_c;
  logic [DATA_width-1:0]  op_sel;

  assign op_sel = SEL_B ? B_IN_SHIFT : A_IN_SHIFT;

  // One-bit step of the working register in the captured mode
  always_comb begin
    step_val = work_q;
    step_c   = work_q[0];
    case (mode_q)
      M_LSL: begin
        step_val = {work_q[DATA_width-2:0], 1'b0};
        step_c   = work_q[DATA_width-1];
      end
      M_LSR: step_val = {1'b0, work_q[DATA_width-1:1]};
      M_ASR: step_val = {work_q[DATA_width-1], work_q[DATA_width-1:1]};
      M_ROR: step_val = {work_q[0], work_q[DATA_width-1:1]};
      default: step_val = work_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    out_d   = out_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (Shift_EN) begin
          work_d  = op_sel;
          cnt_d   = SHAMT;
          mode_d  = ALU_FUN_SHIFT;
          carry_d = 1'b0;
          if (SHAMT == '0) begin
            state_d = S_DONE;
            out_d   = op_sel;
            cout_d  = 1'b0;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d  = step_val;
        carry_d = step_c;
        cnt_d   = cnt_q - SHAMT_width'(1);
        if (cnt_q == SHAMT_width'(1)) begin
          state_d = S_DONE;
          out_d   = step_val;
          cout_d  = step_c;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_SHIFT) begin
    if (!RST_SHIFT) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
    end
  end

  assign BUSY       = (state_q != S_IDLE);
  assign SHIFT_FLAG = (state_q == S_DONE);
  assign SHIFT_OUT  = out_q;
  assign CARRY_OUT  = cout_q;

endmodule
